ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Multi-register transfer sequencer for the Cortex-M0 core. It executes LDM/STM/PUSH/POP by walking a 9-bit register list. For each listed register it issues one word access to the memory port with a req/ready handshake, and it drives the register-file read or write port. It sits between the ControlUnit, which starts it and stalls on `busy`, and the Datapath register file and data memory interface.

## Interface
- `ADDR_W`, 32, memory address width; data width is fixed at 32.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin an operation; accepted only while `busy`=0.
- `is_load` in 1: 1 = LDM/POP (memory to registers), 0 = STM/PUSH.
- `reg_list` in 9: bits 0–7 select R0–R7. Bit 8 selects R14 on a store and R15 on a load.
- `base_addr` in ADDR_W: lowest transfer address, word-aligned.
- `base_reg` in 4: register index that receives the writeback.
- `wb_en` in 1: write `final_addr` back to `base_reg`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse in the last cycle of an operation.
- `final_addr` out ADDR_W: `base_addr` + 4·popcount(list); valid while `done`=1.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write; equals the latched inverse of `is_load`.
- `mem_addr` out ADDR_W: current word address.
- `mem_wdata` out 32: store data; combinationally equals `rf_rdata`.
- `mem_ready` in 1: transfer completes on an edge where `mem_req`=`mem_ready`=1.
- `mem_rdata` in 32: load data; valid when `mem_ready`=1.
- `rf_raddr` out 4: register-file read index (register currently being transferred).
- `rf_rdata` in 32: register-file combinational read data.
- `rf_wr_en` out 1, `rf_waddr` out 4, `rf_wdata` out 32: register-file write port, all registered.

## Operation
- **Latching.** On the edge where `start`=1 and `busy`=0, the block latches `is_load`, `reg_list`, `base_addr`, `base_reg` and `wb_en`. Input changes after that edge are ignored. While `busy`=1, `start` is ignored.
- **FSM states:**
  - IDLE → XFER if the latched list is non-zero, otherwise IDLE → FIN.
  - XFER: `mem_req`=1. The pending register is the lowest set bit of the remaining list, where bit 8 counts as the highest. `rf_raddr` and `mem_addr` are driven for that register. On a completed transfer, the bit is cleared and the address is incremented by 4. XFER → FIN when the last bit is cleared; otherwise XFER holds.
  - FIN → WB if writeback is enabled, otherwise FIN → IDLE.
  - WB → IDLE.
- **Ordering.** The lowest register goes to the lowest address. Address arithmetic wraps modulo 2^ADDR_W.
- **Load writeback to the register file.** In the cycle after each completed load transfer, `rf_wr_en`=1, `rf_waddr` = that register, and `rf_wdata` = the captured `mem_rdata`. The last loaded register is written during FIN.
- **Base writeback (WB state).** `rf_wr_en`=1, `rf_waddr`=`base_reg`, `rf_wdata`=`final_addr`. Writeback is enabled when `wb_en`=1, except when all of the following hold, in which case WB is skipped: the operation is a load, `base_reg`<8, and the `base_reg` bit is set in the list.
- **`done` and `busy`.** `done`=1 in WB when writeback is enabled, otherwise in FIN. `busy`=1 in every cycle that is not IDLE.
- **Stores.** `rf_wr_en` stays 0 for the whole operation.
- **Reset.** Reset is asynchronous and active-low. Any assertion, including mid-operation, forces IDLE and clears every output to 0 immediately: `busy`, `done`, `mem_req`, `mem_we`, `mem_addr`, `rf_raddr`, `rf_wr_en`, `rf_waddr`, `rf_wdata`, `final_addr`. `mem_wdata` follows `rf_rdata`. No partial writeback occurs after reset.

## Timing
- Define N = popcount(list), with `start` accepted at edge 0 and `mem_ready` held at 1:
  - XFER occupies cycles 1..N.
  - FIN is cycle N+1.
  - WB is cycle N+2.
  - `busy` falls in the cycle after `done`, and a new `start` can be accepted at that edge.
- **Stalls.** Each cycle with `mem_req`=1 and `mem_ready`=0 extends XFER by one cycle. `mem_addr`, `mem_we`, `rf_raddr` and `mem_wdata` stay stable during the stall.
- **Empty list.** FIN is cycle 1 and no memory request is issued. `final_addr`=`base_addr`.
- **No conflicts.** Register-file write timing guarantees at most one `rf_wr_en` per cycle.

## Test plan
- **Store, no writeback.** Store, list 0x013, base 0x100, `wb_en`=0, ready high.
  - Expect `mem_addr` 0x100, 0x104, 0x108 in cycles 1–3 with `rf_raddr` 0, 1, 4 and `mem_we`=1.
  - Expect `done` in cycle 4, `final_addr` 0x10C, and no `rf_wr_en`.
- **POP with PC and stall.** Load, list 0x181 (R0, R7, PC), base 0x200, `base_reg` 13, `wb_en`=1. Drop `mem_ready` for two cycles on the second access.
  - Expect `rf_wr_en` writes to R0, R7, R15 with the matching `mem_rdata`.
  - Expect WB to write 0x20C to R13, and `done` in the WB cycle (cycle 7).
- **Base in list.** Load, list 0x004, `base_reg` 2, `wb_en`=1.
  - Expect R2 to receive the loaded value, no WB cycle, and `done` in cycle 2.
- **Empty list.** `reg_list`=0, `wb_en`=1, base 0x40.
  - Expect no `mem_req`, WB to write 0x40 to `base_reg`, and `done` in cycle 2.
- **Address wrap.** Store, list 0x003, base 0xFFFFFFFC.
  - Expect addresses 0xFFFFFFFC and 0x00000000, and `final_addr` 0x00000004.
- **Reset mid-operation.** Drive `rst` low during the second XFER cycle of a 4-register load, and re-apply `start` during the reset.
  - Expect all outputs to go to 0 asynchronously and no further `rf_wr_en`.
  - Expect `start` to be ignored until `rst`=1; after release, a new `start` runs cleanly.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// Walks a 9-bit register list issuing one word memory access per listed register (LDM/STM/PUSH/POP),
// driving the register-file read/write ports and an optional base-register writeback.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [8:0]        reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              wb_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] final_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              rf_wr_en,
    output logic [3:0]        rf_waddr,
    output logic [31:0]       rf_wdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [8:0]        list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic              wb_q, wb_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic [3:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;

    logic [8:0]        cur_bit;
    logic [3:0]        cur_idx;
    logic [3:0]        cur_reg;
    logic              found;

    // Lowest set bit of the remaining list; bit 8 is LR on stores, PC on loads.
    always_comb begin
        cur_bit = '0;
        cur_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (list_q[i] && !found) begin
                found      = 1'b1;
                cur_bit[i] = 1'b1;
                cur_idx    = 4'(i);
            end
        end
        if (cur_bit[8]) begin
            cur_reg = we_q ? 4'd14 : 4'd15;
        end else begin
            cur_reg = cur_idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        list_d     = list_q;
        addr_d     = addr_q;
        base_reg_d = base_reg_q;
        wb_d       = wb_q;
        rf_wr_en_d = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d       = ~is_load;
                    list_d     = reg_list;
                    addr_d     = base_addr;
                    base_reg_d = base_reg;
                    // A load that overwrites its own base keeps the loaded value.
                    wb_d       = wb_en && !(is_load && !base_reg[3] && reg_list[base_reg[2:0]]);
                    state_d    = (|reg_list) ? S_XFER : S_FIN;
                end
            end
            S_XFER: begin
                if (mem_ready) begin
                    list_d = list_q & ~cur_bit;
                    addr_d = addr_q + ADDR_W'(4);
                    if (!we_q) begin
                        rf_wr_en_d = 1'b1;
                        rf_waddr_d = cur_reg;
                        rf_wdata_d = mem_rdata;
                    end
                    if ((list_q & ~cur_bit) == 9'd0) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (wb_q) begin
                    state_d    = S_WB;
                    rf_wr_en_d = 1'b1;
                    rf_waddr_d = base_reg_q;
                    rf_wdata_d = 32'(addr_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            list_q     <= '0;
            addr_q     <= '0;
            base_reg_q <= '0;
            wb_q       <= 1'b0;
            rf_wr_en_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            base_reg_q <= base_reg_d;
            wb_q       <= wb_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // The running address doubles as the final address once the list is drained.
    assign busy       = (state_q != S_IDLE);
    assign done       = ((state_q == S_FIN) && !wb_q) || (state_q == S_WB);
    assign final_addr = addr_q;
    assign mem_req    = (state_q == S_XFER);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = rf_rdata;
    assign rf_raddr   = cur_reg;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed table-driven bench for ldm_stm_sequencer with a simple memory/register-file responder.
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_load;
    logic [8:0]  reg_list;
    logic [31:0] base_addr;
    logic [3:0]  base_reg;
    logic        wb_en;
    logic        busy;
    logic        done;
    logic [31:0] final_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_wr_en;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk;
    int n_fail;

    ldm_stm_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_list(reg_list),
        .base_addr(base_addr), .base_reg(base_reg), .wb_en(wb_en), .busy(busy), .done(done),
        .final_addr(final_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_wr_en(rf_wr_en),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file contents are a recognisable tag of the register index.
    assign rf_rdata = 32'hD000_0000 | {28'd0, rf_raddr};

    typedef struct {
        logic        ld;
        logic [8:0]  list;
        logic [31:0] base;
        logic [3:0]  breg;
        logic        wb;
        int          stall_k;
        int          stall_n;
        int          exp_done;
        logic [31:0] exp_final;
        int          exp_nreq;
        logic        exp_wb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nth_reg(input logic [8:0] l, input logic ld, input int k);
        int seen;
        logic [3:0] r;
        seen = 0;
        r = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (l[i]) begin
                if (seen == k) r = (i == 8) ? (ld ? 4'd15 : 4'd14) : 4'(i);
                seen++;
            end
        end
        return r;
    endfunction

    // Entered #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_op(input vec_t v, input string tag);
        int k;
        int stall_left;
        logic got_done;
        logic wb_seen;
        logic [3:0] er;
        logic [3:0] wq_r[$];
        logic [31:0] wq_d[$];
        k = 0;
        stall_left = v.stall_n;
        got_done = 1'b0;
        wb_seen = 1'b0;
        start = 1'b1; is_load = v.ld; reg_list = v.list; base_addr = v.base;
        base_reg = v.breg; wb_en = v.wb; mem_ready = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs to prove they were latched.
        start = 1'b0; is_load = ~v.ld; reg_list = 9'h1AA; base_addr = 32'hDEAD_BEE0;
        base_reg = ~v.breg; wb_en = ~v.wb;
        for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            if (!done) chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (mem_req) begin
                er = nth_reg(v.list, v.ld, k);
                chk({tag, " mem_addr"}, mem_addr, v.base + 32'(4 * k));
                chk({tag, " rf_raddr"}, {28'd0, rf_raddr}, {28'd0, er});
                chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, ~v.ld});
                chk({tag, " mem_wdata"}, mem_wdata, 32'hD000_0000 | {28'd0, er});
                if (k == v.stall_k && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_rdata = 32'h5EED_0000 ^ mem_addr;
                    if (v.ld) begin
                        wq_r.push_back(er);
                        wq_d.push_back(mem_rdata);
                    end
                    k++;
                end
            end
            if (rf_wr_en) begin
                if (wq_r.size() > 0) begin
                    chk({tag, " rf_waddr"}, {28'd0, rf_waddr}, {28'd0, wq_r.pop_front()});
                    chk({tag, " rf_wdata"}, rf_wdata, wq_d.pop_front());
                end else begin
                    chk({tag, " wb_allowed"}, {31'd0, v.exp_wb}, 32'd1);
                    chk({tag, " wb_waddr"}, {28'd0, rf_waddr}, {28'd0, v.breg});
                    chk({tag, " wb_wdata"}, rf_wdata, v.exp_final);
                    wb_seen = 1'b1;
                end
            end
            if (done) begin
                chk({tag, " done_cycle"}, 32'(cyc), 32'(v.exp_done));
                chk({tag, " final_addr"}, final_addr, v.exp_final);
                got_done = 1'b1;
            end
        end
        if (!got_done) chk({tag, " done_timeout"}, 32'd0, 32'd1);
        chk({tag, " nreq"}, 32'(k), 32'(v.exp_nreq));
        chk({tag, " wb_seen"}, {31'd0, wb_seen}, {31'd0, v.exp_wb});
        chk({tag, " loads_written"}, 32'(wq_r.size()), 32'd0);
        @(posedge clk); #1;
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " idle_wr"}, {31'd0, rf_wr_en}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " rf_raddr"}, {28'd0, rf_raddr}, 32'd0);
        chk({tag, " rf_wr_en"}, {31'd0, rf_wr_en}, 32'd0);
        chk({tag, " rf_waddr"}, {28'd0, rf_waddr}, 32'd0);
        chk({tag, " rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, " final_addr"}, final_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, rf_rdata);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        //           ld    list    base          breg   wb  stk stn done final         nreq wb
        vecs[0] = '{1'b0, 9'h013, 32'h0000_0100, 4'd0,  1'b0, -1, 0,  4, 32'h0000_010C, 3, 1'b0};
        vecs[1] = '{1'b1, 9'h181, 32'h0000_0200, 4'd13, 1'b1,  1, 2,  7, 32'h0000_020C, 3, 1'b1};
        vecs[2] = '{1'b1, 9'h004, 32'h0000_0300, 4'd2,  1'b1, -1, 0,  2, 32'h0000_0304, 1, 1'b0};
        vecs[3] = '{1'b0, 9'h000, 32'h0000_0040, 4'd5,  1'b1, -1, 0,  2, 32'h0000_0040, 0, 1'b1};
        vecs[4] = '{1'b0, 9'h003, 32'hFFFF_FFFC, 4'd0,  1'b0, -1, 0,  3, 32'h0000_0004, 2, 1'b0};
        vecs[5] = '{1'b0, 9'h100, 32'h0000_0080, 4'd13, 1'b1, -1, 0,  3, 32'h0000_0084, 1, 1'b1};
        vecs[6] = '{1'b1, 9'h1FF, 32'h0000_1000, 4'd3,  1'b1, -1, 0, 10, 32'h0000_1024, 9, 1'b0};
        vecs[7] = '{1'b1, 9'h0F0, 32'h0000_0020, 4'd9,  1'b1,  0, 1,  7, 32'h0000_0030, 4, 1'b1};
        vecs[8] = '{1'b1, 9'h101, 32'h0000_0500, 4'd8,  1'b1, -1, 0,  4, 32'h0000_0508, 2, 1'b1};

        rst = 1'b0; start = 1'b0; is_load = 1'b0; reg_list = '0; base_addr = '0;
        base_reg = '0; wb_en = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the second XFER cycle of a 4-register load.
        start = 1'b1; is_load = 1'b1; reg_list = 9'h0F0; base_addr = 32'h40;
        base_reg = 4'd1; wb_en = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst rf_wr_en", {31'd0, rf_wr_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        start = 1'b1; reg_list = 9'h00F;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start busy", {31'd0, busy}, 32'd0);
        chk("rst_start req", {31'd0, mem_req}, 32'd0);
        chk("rst_start wr", {31'd0, rf_wr_en}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst busy", {31'd0, busy}, 32'd0);
        chk("post_rst wr", {31'd0, rf_wr_en}, 32'd0);
        run_op(vecs[0], "after_rst");
        run_op(vecs[1], "after_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
